// File: rtl/ahb_lite_wb_bridge.sv
// AHB-Lite responder that reissues every accepted transfer as one Wishbone
// classic cycle toward the 16550 UART register file.
//
// Parameters: ADDR_W  - Wishbone word-address width (wb_adr_o = HADDR[ADDR_W+1:2])
//             TIMEOUT - max wb_stb_o cycles without ack/err (1..65535)
// Clock/reset: wb_clk_i, wb_rst_i (asynchronous, active-high)
// AHB side:    HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY in;
//              HREADYOUT, HRESP, HRDATA out
// WB side:     wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o out;
//              wb_dat_i, wb_ack_i, wb_err_i in
// Optional:    define AHB_WB_BRIDGE_TIMEOUT_EN to abort a Wishbone cycle that
//              sees no ack/err within TIMEOUT cycles (AHB ERROR response).
module ahb_lite_wb_bridge #(
    parameter int ADDR_W  = 3,
    parameter int TIMEOUT = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic [2:0]        HSIZE,
    input  logic              HWRITE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [31:0]       HRDATA,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [31:0]       wb_dat_o,
    input  logic [31:0]       wb_dat_i,
    output logic [3:0]        wb_sel_o,
    output logic              wb_we_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    input  logic              wb_ack_i,
    input  logic              wb_err_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WB   = 2'd1;
    localparam logic [1:0] S_ERR1 = 2'd2;
    localparam logic [1:0] S_ERR2 = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       accept;
    logic       legal;
    logic [3:0] lane;
    logic       timeout;
    logic       unused_bits;

    assign unused_bits = ^{HADDR[31:ADDR_W+2], HTRANS[0]};

    // ERR2 completes the error response and may take a new address phase.
    assign HREADYOUT = (state == S_IDLE) || (state == S_ERR2);
    assign HRESP     = (state == S_ERR1) || (state == S_ERR2);
    assign wb_cyc_o  = (state == S_WB);
    assign wb_stb_o  = (state == S_WB);
    assign wb_dat_o  = HWDATA;

    assign accept = HREADYOUT & HSEL & HREADY & HTRANS[1];

    always_comb begin
        lane  = 4'b0000;
        legal = 1'b1;
        case (HSIZE)
            3'd0: lane = 4'b0001 << HADDR[1:0];
            3'd1: begin
                lane  = 4'b0011 << {HADDR[1], 1'b0};
                legal = !HADDR[0];
            end
            3'd2: begin
                lane  = 4'b1111;
                legal = (HADDR[1:0] == 2'b00);
            end
            default: legal = 1'b0;
        endcase
    end

`ifdef AHB_WB_BRIDGE_TIMEOUT_EN
    logic [15:0] to_cnt;

    // Counter is zero on the first WB cycle, so TIMEOUT stb cycles elapse.
    assign timeout = (to_cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            to_cnt <= 16'd0;
        end else if (state != S_WB) begin
            to_cnt <= 16'd0;
        end else if (!wb_ack_i && !wb_err_i) begin
            to_cnt <= to_cnt + 16'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_ERR2: begin
                if (accept) begin
                    state_nxt = legal ? S_WB : S_ERR1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            // err beats ack; ack beats a coincident timeout
            S_WB: begin
                if (wb_err_i) begin
                    state_nxt = S_ERR1;
                end else if (wb_ack_i) begin
                    state_nxt = S_IDLE;
                end else if (timeout) begin
                    state_nxt = S_ERR1;
                end
            end
            S_ERR1: state_nxt = S_ERR2;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= S_IDLE;
            wb_adr_o <= '0;
            wb_sel_o <= 4'b0000;
            wb_we_o  <= 1'b0;
            HRDATA   <= 32'd0;
        end else begin
            state <= state_nxt;
            if (accept && legal) begin
                wb_adr_o <= HADDR[ADDR_W+1:2];
                wb_sel_o <= lane;
                wb_we_o  <= HWRITE;
            end
            if (state == S_WB && wb_ack_i && !wb_err_i && !wb_we_o) begin
                HRDATA <= wb_dat_i;
            end
        end
    end

endmodule

// File: doc/ahb_lite_wb_bridge.md
# ahb_lite_wb_bridge

AHB-Lite responder that terminates SCR1 data-memory transfers and reissues each one as a single Wishbone classic cycle toward the uart_top (16550) register file. It sits between the core's dmem AHB port and the UART's Wishbone slave, replacing the ad-hoc read/valid glue around the UART. It generates wait states until the Wishbone ack arrives. Failures produce a two-cycle AHB ERROR response: illegal size, misalignment, wb_err_i, or timeout.

## Interface
- ADDR_W, 3: Wishbone word-address width; wb_adr_o = HADDR[ADDR_W+1:2].
- TIMEOUT, 255: maximum cycles wb_stb_o stays high without ack/err (only with timeout macro); legal range 1..65535.
- wb_clk_i  in  1  single clock for both sides.
- wb_rst_i  in  1  asynchronous, active-high reset.
- HSEL  in  1  responder select.
- HADDR  in  32  address-phase address.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HSIZE  in  3  0=byte, 1=half, 2=word; larger values are illegal.
- HWRITE  in  1  write strobe of the address phase.
- HWDATA  in  32  write data (data phase).
- HREADY  in  1  bus-level ready (address phase qualifier).
- HREADYOUT  out  1  responder ready.
- HRESP  out  1  0=OKAY, 1=ERROR.
- HRDATA  out  32  read data.
- wb_adr_o  out  ADDR_W  Wishbone word address.
- wb_dat_o  out  32  Wishbone write data.
- wb_dat_i  in  32  Wishbone read data.
- wb_sel_o  out  4  byte-lane selects.
- wb_we_o, wb_cyc_o, wb_stb_o  out  1 each  Wishbone control.
- wb_ack_i, wb_err_i  in  1 each  Wishbone termination.

## Operation
- Accept: HSEL & HREADY & HTRANS[1] at a rising edge. Register addr, size, write, and lane mask. HTRANS IDLE/BUSY selected: zero-wait OKAY, no Wishbone cycle.
- Lane mask: byte → 1<<HADDR[1:0]; half → 4'b0011<<{HADDR[1],1'b0}; word → 4'b1111.
- Legality: HSIZE>2, half with HADDR[0]=1, or word with HADDR[1:0]≠0 goes to ERR1. No Wishbone cycle is issued.
- States: IDLE, WB, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=0. Legal accept → WB. Illegal accept → ERR1.
  - WB: wb_cyc_o = wb_stb_o = 1, HREADYOUT=0. wb_dat_o = HWDATA; the master holds it stable while HREADYOUT=0. wb_we_o, wb_adr_o, wb_sel_o come from the registered address phase.
  - WB with wb_ack_i: capture wb_dat_i into HRDATA (reads only) and go to IDLE. The next cycle is the completing OKAY.
  - WB with wb_err_i, or with both ack and err: go to ERR1; err wins.
  - ERR1: HRESP=1, HREADYOUT=0 → ERR2.
  - ERR2: HRESP=1, HREADYOUT=1. A new accept in this cycle is handled exactly as in IDLE.
- Back-to-back: an address phase accepted in the completing cycle (IDLE with HREADYOUT=1) goes straight to WB with no idle gap.
- HRDATA holds its last captured value. It is not cleared between transfers.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_adr_o=0, wb_sel_o=0. State is IDLE.
- Address phase at T0. wb_stb_o is high from T1.
- Ack at Tk (k≥1) gives HREADYOUT=1 and valid HRDATA at Tk+1. Minimum data phase is 2 cycles (1 wait state).
- wb_cyc_o/wb_stb_o deassert in the cycle after ack/err. They never stay high beyond that.
- Illegal transfer: HRESP=1 at T1 (HREADYOUT=0) and T2 (HREADYOUT=1).
- wb_rst_i asserted mid-transfer: all outputs reach reset values asynchronously. The in-flight Wishbone cycle is abandoned and no AHB response is completed.

## Configuration
- AHB_WB_BRIDGE_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to WB and increments each cycle in WB without ack/err.
  - Reaching TIMEOUT drops cyc/stb and goes to ERR1.
  - An ack in the same cycle as the timeout wins: OKAY.
- Not defined: no counter; WB waits indefinitely for ack/err.

## Test plan
- Word write: HADDR=0x0000_0004, HWDATA=0x0000_00A5, ack on 1st stb cycle → wb_adr_o=1, wb_sel_o=4'hF, wb_we_o=1, wb_dat_o=0xA5; OKAY at T2.
- Byte read: HADDR=0x0000_0016, HSIZE=0, ack after 3 wait cycles returning 0x00C3_0000 → wb_sel_o=4'b0100, wb_adr_o=5; HRDATA=0x00C3_0000 with HREADYOUT=1 at T5.
- Misaligned half: HADDR=0x3, HSIZE=1 → no wb_cyc_o; HRESP=1 at T1/T2, HREADYOUT 0 then 1.
- Back-to-back: write 0x1 to addr 0x0, then read 0x8 presented in the completing cycle → second wb_stb_o rises the following cycle, with no idle gap.
- wb_err_i during read → cyc/stb drop next cycle, followed by the two-cycle ERROR. With AHB_WB_BRIDGE_TIMEOUT_EN and TIMEOUT=4 and no ack → ERROR after 4 stb cycles.
- Reset mid-WB (wb_rst_i pulsed while wb_stb_o=1) → wb_stb_o=0 immediately, HREADYOUT=1. The next transfer completes normally.
